// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction-fetch stage.
// Owns the program counter, addresses imem, and registers the fetched
// instruction into the IF/ID register. Handles stalls, branch redirects
// and the CBZ XZR,#0 end-of-program self-loop (HALT state).
// Optional feature macro: FETCH_PERFCNT_EN adds a saturating 32-bit
// accepted-fetch counter on port fetch_count.
module fetch_stage #(
  parameter int          N         = 64,
  parameter int          AW        = 6,
  parameter logic [31:0] HALT_WORD = 32'hb400001f
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  input  logic          stall,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  output logic [31:0]   ifid_instr,
  output logic [N-1:0]  ifid_pc,
  output logic          ifid_valid,
  output logic          halted
`ifdef FETCH_PERFCNT_EN
  ,
  output logic [31:0]   fetch_count
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t         state_reg;
  logic [N-1:0]   pc_reg;
  logic [31:0]    instr_reg;
  logic [N-1:0]   ipc_reg;
  logic           valid_reg;
  logic           halted_reg;
  logic [N-1:0]   target_pc;

  // Branch targets are forced to word alignment; the low two bits are dropped.
  assign target_pc = redirect_pc & ~N'(3);

  // imem is asynchronous-read, so the word address is a pure slice of the PC.
  assign imem_addr  = pc_reg[AW+1:2];
  assign ifid_instr = instr_reg;
  assign ifid_pc    = ipc_reg;
  assign ifid_valid = valid_reg;
  assign halted     = halted_reg;

  // Fetch FSM: PC, IF/ID register and halt flag, priority redirect > stall > fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      pc_reg     <= '0;
      instr_reg  <= '0;
      ipc_reg    <= '0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else if (redirect) begin
      // Redirect wins in both states: load target, flush IF/ID, resume running.
      state_reg  <= RUN;
      pc_reg     <= target_pc;
      instr_reg  <= '0;
      ipc_reg    <= '0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else if (state_reg == HALT) begin
      // Halted: PC and IF/ID contents hold, stall is irrelevant, emit bubbles.
      valid_reg  <= 1'b0;
      halted_reg <= 1'b1;
    end else if (!stall) begin
      instr_reg <= imem_q;
      ipc_reg   <= pc_reg;
      valid_reg <= 1'b1;
      pc_reg    <= pc_reg + N'(4);
      if (imem_q == HALT_WORD) begin
        state_reg <= HALT;
      end
    end
  end

`ifdef FETCH_PERFCNT_EN
  logic        fetch_accept;
  logic [31:0] count_reg;

  assign fetch_accept = (state_reg == RUN) && !redirect && !stall;
  assign fetch_count  = count_reg;

  // Saturating count of instructions accepted into IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (fetch_accept && (count_reg != 32'hffffffff)) begin
      count_reg <= count_reg + 32'd1;
    end
  end
`endif

endmodule
